apple_eat_ctrl: RTL and testbench
=================================

Name: apple_eat_ctrl

Overview:
- Consumer side of the apple generator interface.
- Takes the apple box (Hl/Hr/Vu/Vd) and the snake head position, detects when the head overlaps the apple, and drives `refle` back to clear the apple.
- Holds the `rand` value that places the apple, and keeps a 2-digit BCD score.
- Clocked on the game tick.

Parameters:
- HEAD_SIZE, 15, head square edge length in pixels (head box spans head_x..head_x+HEAD_SIZE).
- RESPAWN_TICKS, 2, ticks the apple stays cleared after EATEN, before re-arming (0 allowed).
- RAND_SEED, 8'd10, value loaded into rand_out on reset.

Ports:
- clk_1hz  in  1  game tick clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  game running; 0 forces IDLE.
- rand_in  in  8  free-running pseudo-random value.
- Hl  in  10  apple left edge.
- Hr  in  10  apple right edge.
- Vu  in  10  apple top edge.
- Vd  in  10  apple bottom edge.
- head_x  in  10  snake head left edge.
- head_y  in  10  snake head top edge.
- refle  out  1  apple clear request to generator; high means cleared.
- rand_out  out  8  latched placement value to generator; stable while ARMED.
- eat_pulse  out  1  one-tick pulse per apple eaten.
- score_bcd  out  8  [7:4] tens, [3:0] ones, BCD 00..99.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at edge):
  - state=IDLE, refle=0, eat_pulse=0, score_bcd=8'h00, rand_out=RAND_SEED, respawn counter=0.
  - rst has priority over every other input.
- apple_valid = (Hr != 0).
- hit = apple_valid && head_x <= Hr && head_x+HEAD_SIZE >= Hl && head_y <= Vd && head_y+HEAD_SIZE >= Vu.
  - Sums are computed at 11 bits; no wrap-around.
  - Edge-touching counts as a hit.
- States: IDLE, ARMED, EATEN, RESPAWN.
- IDLE:
  - Outputs: refle=0, eat_pulse=0.
  - start=1 -> ARMED; rand_out<=rand_in on that edge.
- ARMED:
  - Outputs: refle=0.
  - hit=1 -> EATEN. On that same edge: eat_pulse<=1, refle<=1, rand_out<=rand_in, score incremented.
  - Otherwise stay in ARMED.
  - Latency: hit sampled at edge k; refle, eat_pulse, score and rand_out all change after edge k.
- EATEN (exactly one tick):
  - eat_pulse returns to 0 at the next edge.
  - RESPAWN_TICKS=0 -> ARMED with refle<=0.
  - Else -> RESPAWN with counter loaded to RESPAWN_TICKS-1.
- RESPAWN:
  - refle stays 1.
  - When counter==0 -> ARMED with refle<=0.
  - Else counter decrements.
- start=0 at any edge (not reset):
  - -> IDLE, refle<=0, eat_pulse<=0.
  - Score and rand_out are held.
  - Overrides a simultaneous hit: no score increment.
- Score increment:
  - BCD: ones 9 -> 0 with tens+1.
  - At 8'h99, saturates: score unchanged, eat_pulse still fires.
- A hit is ignored in EATEN and RESPAWN; the generator output is zero then, so apple_valid=0 anyway.
- rand_in changes while ARMED do not affect rand_out, so the apple does not move.
- Reset mid-RESPAWN: immediate IDLE, counter cleared, refle=0 at that edge.

Decomposition:
- Shared package apple_pkg:
  - state enum {IDLE, ARMED, EATEN, RESPAWN}.
  - APPLE_SIZE=15, APPLE_V_OFFSET=60, APPLE_H_OFFSET=170, HEAD_SIZE default.
  - BCD_MAX=8'h99.
- Sub-module apple_box_overlap: combinational.
  - Inputs: two boxes.
  - Output: hit.
  - Reused for wall and self-collision later.
- FSM, counter and BCD score stay in apple_eat_ctrl.

Test Plan:
- rst=1 for 2 ticks, then release with start=0 -> refle=0, eat_pulse=0, score_bcd=00, rand_out=10, state IDLE.
- Entering play and eating:
  - start=1, rand_in=20 -> rand_out=20 after the edge.
  - Hold apple box Hl=210, Hr=225, Vu=80, Vd=95; place head_x=200, head_y=90.
  - Expected: one tick later refle=1, eat_pulse=1 for exactly one tick, score 01, rand_out=new rand_in.
  - refle=1 for 1+RESPAWN_TICKS=3 ticks total, then 0.
- Head at head_x=226 (one pixel right of Hr), head_y=80 -> no hit, state ARMED, score unchanged for 10 ticks.
- Score preloaded by 99 eats -> score 99. Next eat -> eat_pulse=1, score stays 99.
- Score carry: from 09, one eat -> 10.
- Overlap present and start dropped on the same edge -> IDLE, no eat_pulse, score unchanged, refle=0.
- rst asserted while in RESPAWN -> next tick IDLE, refle=0, score 00, rand_out=10.

Source files
------------

// File: rtl/apple_pkg.sv
// Shared types and constants for the apple generator / consumer pair.
package apple_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StEaten,
    StRespawn
  } apple_state_e;

  localparam int unsigned APPLE_SIZE     = 15;
  localparam int unsigned APPLE_V_OFFSET = 60;
  localparam int unsigned APPLE_H_OFFSET = 170;
  localparam int unsigned HEAD_SIZE_DEF  = 15;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // Two-digit BCD increment that sticks at BCD_MAX.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/apple_box_overlap.sv
// Axis-aligned box overlap test; touching edges count as overlap.
module apple_box_overlap #(
  parameter int unsigned W = 11
) (
  input  logic [W-1:0] a_l_i,
  input  logic [W-1:0] a_r_i,
  input  logic [W-1:0] a_t_i,
  input  logic [W-1:0] a_b_i,
  input  logic [W-1:0] b_l_i,
  input  logic [W-1:0] b_r_i,
  input  logic [W-1:0] b_t_i,
  input  logic [W-1:0] b_b_i,
  output logic         hit_o
);

  always_comb begin
    hit_o = (a_l_i <= b_r_i) && (a_r_i >= b_l_i) &&
            (a_t_i <= b_b_i) && (a_b_i >= b_t_i);
  end

endmodule

// File: rtl/apple_eat_ctrl.sv
// Apple consumer: detects the head eating the apple, clears it for a while,
// relatches the placement value and keeps a saturating two-digit BCD score.
module apple_eat_ctrl
  import apple_pkg::*;
#(
  parameter int unsigned HEAD_SIZE     = HEAD_SIZE_DEF,
  parameter int unsigned RESPAWN_TICKS = 2,
  parameter logic [7:0]  RAND_SEED     = 8'd10
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rand_in,
  input  logic [9:0] Hl,
  input  logic [9:0] Hr,
  input  logic [9:0] Vu,
  input  logic [9:0] Vd,
  input  logic [9:0] head_x,
  input  logic [9:0] head_y,
  output logic       refle,
  output logic [7:0] rand_out,
  output logic       eat_pulse,
  output logic [7:0] score_bcd
);

  // Counter only ever holds RESPAWN_TICKS-1 down to 0.
  localparam int unsigned CntW = (RESPAWN_TICKS > 2) ? $clog2(RESPAWN_TICKS) : 1;

  apple_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            refle_q, refle_d;
  logic            eat_q, eat_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      rand_q, rand_d;

  logic [10:0] head_r, head_b;
  logic        box_hit;
  logic        apple_valid;
  logic        hit;

  // Widen to 11 bits so head_x + HEAD_SIZE cannot wrap.
  always_comb begin
    head_r = {1'b0, head_x} + 11'(HEAD_SIZE);
    head_b = {1'b0, head_y} + 11'(HEAD_SIZE);
  end

  apple_box_overlap #(
    .W (11)
  ) u_overlap (
    .a_l_i ({1'b0, head_x}),
    .a_r_i (head_r),
    .a_t_i ({1'b0, head_y}),
    .a_b_i (head_b),
    .b_l_i ({1'b0, Hl}),
    .b_r_i ({1'b0, Hr}),
    .b_t_i ({1'b0, Vu}),
    .b_b_i ({1'b0, Vd}),
    .hit_o (box_hit)
  );

  assign apple_valid = (Hr != 10'd0);
  assign hit         = apple_valid && box_hit;

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      refle_q <= 1'b0;
      eat_q   <= 1'b0;
      score_q <= 8'h00;
      rand_q  <= RAND_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      refle_q <= refle_d;
      eat_q   <= eat_d;
      score_q <= score_d;
      rand_q  <= rand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StArmed;
        StArmed:   if (hit) state_d = StEaten;
        StEaten:   state_d = (RESPAWN_TICKS == 0) ? StArmed : StRespawn;
        StRespawn: if (cnt_q == '0) state_d = StArmed;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    refle_d = refle_q;
    eat_d   = 1'b0;
    score_d = score_q;
    rand_d  = rand_q;
    if (!start) begin
      // Dropping start wins over a simultaneous hit; score and rand are held.
      refle_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          refle_d = 1'b0;
          rand_d  = rand_in;
        end
        StArmed: begin
          refle_d = 1'b0;
          if (hit) begin
            refle_d = 1'b1;
            eat_d   = 1'b1;
            rand_d  = rand_in;
            score_d = bcd_inc_sat(score_q);
          end
        end
        StEaten: begin
          if (RESPAWN_TICKS == 0) begin
            refle_d = 1'b0;
          end else begin
            cnt_d = CntW'(RESPAWN_TICKS - 1);
          end
        end
        StRespawn: begin
          if (cnt_q == '0) begin
            refle_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: refle_d = 1'b0;
      endcase
    end
  end

  assign refle     = refle_q;
  assign eat_pulse = eat_q;
  assign score_bcd = score_q;
  assign rand_out  = rand_q;

endmodule

// File: tb/tb_apple_eat_ctrl.sv
// Directed bench for apple_eat_ctrl with a queue of expected post-edge outputs.
module tb_apple_eat_ctrl;

  logic       clk_1hz = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] rand_in = 8'd0;
  logic [9:0] Hl      = 10'd210;
  logic [9:0] Hr      = 10'd225;
  logic [9:0] Vu      = 10'd80;
  logic [9:0] Vd      = 10'd95;
  logic [9:0] head_x  = 10'd226;
  logic [9:0] head_y  = 10'd80;
  logic       refle;
  logic [7:0] rand_out;
  logic       eat_pulse;
  logic [7:0] score_bcd;

  apple_eat_ctrl #(
    .HEAD_SIZE     (15),
    .RESPAWN_TICKS (2),
    .RAND_SEED     (8'd10)
  ) dut (
    .clk_1hz   (clk_1hz),
    .rst       (rst),
    .start     (start),
    .rand_in   (rand_in),
    .Hl        (Hl),
    .Hr        (Hr),
    .Vu        (Vu),
    .Vd        (Vd),
    .head_x    (head_x),
    .head_y    (head_y),
    .refle     (refle),
    .rand_out  (rand_out),
    .eat_pulse (eat_pulse),
    .score_bcd (score_bcd)
  );

  always #5 clk_1hz = ~clk_1hz;

  typedef struct {
    string      tag;
    logic       refle;
    logic       eat;
    logic [7:0] score;
    logic [7:0] rnd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Queue the outputs expected after the next rising edge, then compare.
  task automatic tick(input string tag, input logic r, input logic e,
                      input logic [7:0] s, input logic [7:0] rn);
    exp_t x;
    x.tag = tag; x.refle = r; x.eat = e; x.score = s; x.rnd = rn;
    sb.push_back(x);
    @(posedge clk_1hz);
    #1;
    x = sb.pop_front();
    checks++;
    assert (refle === x.refle) else begin
      errors++;
      $error("FAIL %s refle observed %0b expected %0b", x.tag, refle, x.refle);
    end
    checks++;
    assert (eat_pulse === x.eat) else begin
      errors++;
      $error("FAIL %s eat_pulse observed %0b expected %0b", x.tag, eat_pulse, x.eat);
    end
    checks++;
    assert (score_bcd === x.score) else begin
      errors++;
      $error("FAIL %s score_bcd observed %0h expected %0h", x.tag, score_bcd, x.score);
    end
    checks++;
    assert (rand_out === x.rnd) else begin
      errors++;
      $error("FAIL %s rand_out observed %0d expected %0d", x.tag, rand_out, x.rnd);
    end
  endtask

  // One full eat: hit edge, EATEN, RESPAWN, back to ARMED with the head moved away.
  task automatic eat_seq(input string tag, input logic [7:0] r,
                         input logic [9:0] hx, input logic [9:0] hy);
    head_x  = hx;
    head_y  = hy;
    rand_in = r;
    n++;
    tick(tag, 1'b1, 1'b1, to_bcd(n), r);
    head_x  = 10'd226;
    head_y  = 10'd80;
    rand_in = r + 8'd1;
    tick({tag, "_eaten"}, 1'b1, 1'b0, to_bcd(n), r);
    tick({tag, "_resp"},  1'b1, 1'b0, to_bcd(n), r);
    tick({tag, "_rearm"}, 1'b0, 1'b0, to_bcd(n), r);
  endtask

  logic [9:0] off_x [4] = '{10'd226, 10'd210, 10'd194, 10'd210};
  logic [9:0] off_y [4] = '{10'd80,  10'd64,  10'd80,  10'd96};

  initial begin
    tick("rst0", 1'b0, 1'b0, 8'h00, 8'd10);
    tick("rst1", 1'b0, 1'b0, 8'h00, 8'd10);
    rst     = 1'b0;
    rand_in = 8'd55;
    tick("idle", 1'b0, 1'b0, 8'h00, 8'd10);

    start   = 1'b1;
    rand_in = 8'd20;
    tick("arm", 1'b0, 1'b0, 8'h00, 8'd20);

    rand_in = 8'd33;
    for (int i = 0; i < 10; i++) begin
      head_x = off_x[i % 4];
      head_y = off_y[i % 4];
      tick("miss", 1'b0, 1'b0, 8'h00, 8'd20);
    end

    // Cleared apple box (Hr==0) would geometrically overlap a head at 0,0.
    Hl = 10'd0; Hr = 10'd0; Vu = 10'd0; Vd = 10'd0;
    head_x = 10'd0; head_y = 10'd0;
    for (int i = 0; i < 3; i++) tick("invalid", 1'b0, 1'b0, 8'h00, 8'd20);
    Hl = 10'd210; Hr = 10'd225; Vu = 10'd80; Vd = 10'd95;
    head_x = 10'd226; head_y = 10'd80;
    tick("restore", 1'b0, 1'b0, 8'h00, 8'd20);

    // First eat, head left on the apple through EATEN/RESPAWN.
    head_x = 10'd200; head_y = 10'd90; rand_in = 8'd44;
    n = 1;
    tick("eat1", 1'b1, 1'b1, 8'h01, 8'd44);
    rand_in = 8'd45;
    tick("eat1_eaten", 1'b1, 1'b0, 8'h01, 8'd44);
    tick("eat1_resp",  1'b1, 1'b0, 8'h01, 8'd44);
    tick("eat1_rearm", 1'b0, 1'b0, 8'h01, 8'd44);
    head_x = 10'd226; head_y = 10'd80;
    tick("eat1_armed", 1'b0, 1'b0, 8'h01, 8'd44);

    eat_seq("edge_lo", 8'd60, 10'd195, 10'd80);
    eat_seq("edge_hi", 8'd61, 10'd225, 10'd95);

    // Start dropped on the same edge as an overlap.
    head_x = 10'd200; head_y = 10'd90; rand_in = 8'd77;
    start = 1'b0;
    tick("drop",  1'b0, 1'b0, 8'h03, 8'd61);
    tick("idle2", 1'b0, 1'b0, 8'h03, 8'd61);
    start = 1'b1; rand_in = 8'd50;
    head_x = 10'd226; head_y = 10'd80;
    tick("rearm2", 1'b0, 1'b0, 8'h03, 8'd50);

    while (n < 99) eat_seq("run", 8'(n + 100), 10'd200, 10'd90);

    // Saturating eat, then reset while in RESPAWN.
    head_x = 10'd200; head_y = 10'd90; rand_in = 8'd200;
    tick("sat", 1'b1, 1'b1, 8'h99, 8'd200);
    head_x = 10'd226; head_y = 10'd80; rand_in = 8'd201;
    tick("sat_eaten", 1'b1, 1'b0, 8'h99, 8'd200);
    rst = 1'b1;
    tick("rst_resp", 1'b0, 1'b0, 8'h00, 8'd10);
    rst = 1'b0; rand_in = 8'd5;
    tick("rearm3", 1'b0, 1'b0, 8'h00, 8'd5);
    n = 0;
    eat_seq("post_rst", 8'd6, 10'd200, 10'd90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
